// File: rtl/riscv_memrsp.sv
// Memory response unit: turns one translated CPU request into a single BIU access
// and returns exactly one response (data, bus error or misalignment) to the CPU.
module riscv_memrsp #(
    parameter int XLEN = 32,
    parameter int PLEN = (XLEN == 32) ? 34 : 56
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            req_i,
    input  logic [PLEN-1:0] adr_i,
    input  logic [2:0]      size_i,
    input  logic            lock_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] d_i,
    input  logic            flush_i,
    output logic            stall_o,

    output logic            ack_o,
    output logic [XLEN-1:0] q_o,
    output logic            err_o,
    output logic            misaligned_o,

    output logic            biu_stb_o,
    output logic [PLEN-1:0] biu_adri_o,
    output logic [2:0]      biu_size_o,
    output logic            biu_lock_o,
    output logic            biu_we_o,
    output logic [XLEN-1:0] biu_d_o,
    input  logic            biu_stb_ack_i,
    input  logic            biu_d_ack_i,
    input  logic [XLEN-1:0] biu_q_i,
    input  logic            biu_err_i
);

    // biu_size_t encoding: BYTE=0, HWORD=1, WORD=2, DWORD=3 (larger sizes are never flagged)
    localparam logic [2:0] SZ_HWORD = 3'd1;
    localparam logic [2:0] SZ_WORD  = 3'd2;
    localparam logic [2:0] SZ_DWORD = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STB  = 2'd1,
        ST_DATA = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;
    logic            w_misaligned;
    logic            w_done;
    logic            w_busy;
    logic            r_kill;
    logic            r_err;
    logic            r_mis;
    logic [PLEN-1:0] r_adr;
    logic [2:0]      r_size;
    logic            r_lock;
    logic            r_we;
    logic [XLEN-1:0] r_d;
    logic [XLEN-1:0] r_q;

    always_comb begin
        w_misaligned = 1'b0;
        case (size_i)
            SZ_HWORD: w_misaligned = adr_i[0];
            SZ_WORD:  w_misaligned = |adr_i[1:0];
            SZ_DWORD: w_misaligned = |adr_i[2:0];
            default:  w_misaligned = 1'b0;
        endcase
    end

    assign w_accept = (r_state == ST_IDLE) && req_i && !flush_i;
    assign w_busy   = (r_state == ST_STB) || (r_state == ST_DATA);
    // Completion may arrive together with the strobe acknowledge.
    assign w_done   = ((r_state == ST_STB) && biu_stb_ack_i && (biu_d_ack_i || biu_err_i)) ||
                      ((r_state == ST_DATA) && (biu_d_ack_i || biu_err_i));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        stall_o      = (r_state != ST_IDLE);
        biu_stb_o    = (r_state == ST_STB);
        ack_o        = 1'b0;
        err_o        = 1'b0;
        misaligned_o = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_misaligned ? ST_RSP : ST_STB;
                end
            end
            ST_STB: begin
                if (biu_stb_ack_i) begin
                    w_state_nxt = (biu_d_ack_i || biu_err_i) ? ST_RSP : ST_DATA;
                end
            end
            ST_DATA: begin
                if (biu_d_ack_i || biu_err_i) begin
                    w_state_nxt = ST_RSP;
                end
            end
            ST_RSP: begin
                w_state_nxt  = ST_IDLE;
                ack_o        = !r_kill && !flush_i;
                err_o        = ack_o && r_err;
                misaligned_o = ack_o && r_mis;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_kill <= 1'b0;
            r_err  <= 1'b0;
            r_mis  <= 1'b0;
            r_adr  <= '0;
            r_size <= '0;
            r_lock <= 1'b0;
            r_we   <= 1'b0;
            r_d    <= '0;
            r_q    <= '0;
        end else begin
            if (w_accept) begin
                r_adr  <= adr_i;
                r_size <= size_i;
                r_lock <= lock_i;
                r_we   <= we_i;
                r_d    <= d_i;
                r_err  <= 1'b0;
                r_mis  <= w_misaligned;
            end
            if (w_done) begin
                r_err <= biu_err_i;
                r_mis <= 1'b0;
                if (!r_we) begin
                    r_q <= biu_q_i;
                end
            end
            // A flushed access still finishes on the bus; only its response is dropped.
            if (w_busy && flush_i) begin
                r_kill <= 1'b1;
            end
            if (r_state == ST_RSP) begin
                r_kill <= 1'b0;
                r_lock <= 1'b0;
            end
        end
    end

    assign q_o        = r_q;
    assign biu_adri_o = r_adr;
    assign biu_size_o = r_size;
    assign biu_lock_o = r_lock;
    assign biu_we_o   = r_we;
    assign biu_d_o    = r_d;

endmodule

// File: tb/tb_riscv_memrsp.sv
// Bench for riscv_memrsp: a driver plays CPU and BIU, pushes expected responses,
// and an independent monitor pops them whenever ack_o is seen.
module tb_riscv_memrsp;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i;
    logic [33:0] adr_i;
    logic [2:0]  size_i;
    logic        lock_i;
    logic        we_i;
    logic [31:0] d_i;
    logic        flush_i;
    logic        stall_o;
    logic        ack_o;
    logic [31:0] q_o;
    logic        err_o;
    logic        misaligned_o;
    logic        biu_stb_o;
    logic [33:0] biu_adri_o;
    logic [2:0]  biu_size_o;
    logic        biu_lock_o;
    logic        biu_we_o;
    logic [31:0] biu_d_o;
    logic        biu_stb_ack_i;
    logic        biu_d_ack_i;
    logic [31:0] biu_q_i;
    logic        biu_err_i;

    riscv_memrsp #(.XLEN(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_i(req_i), .adr_i(adr_i), .size_i(size_i), .lock_i(lock_i), .we_i(we_i), .d_i(d_i),
        .flush_i(flush_i), .stall_o(stall_o),
        .ack_o(ack_o), .q_o(q_o), .err_o(err_o), .misaligned_o(misaligned_o),
        .biu_stb_o(biu_stb_o), .biu_adri_o(biu_adri_o), .biu_size_o(biu_size_o),
        .biu_lock_o(biu_lock_o), .biu_we_o(biu_we_o), .biu_d_o(biu_d_o),
        .biu_stb_ack_i(biu_stb_ack_i), .biu_d_ack_i(biu_d_ack_i),
        .biu_q_i(biu_q_i), .biu_err_i(biu_err_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] q;
        logic        err;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          n_pushed = 0;
    int          n_acks   = 0;
    logic [31:0] model_q;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Natural alignment: an access of 2**size bytes must start on a multiple of that size.
    function automatic bit is_mis(logic [2:0] size, logic [33:0] adr);
        int nbytes;
        if (size > 3) return 1'b0;
        nbytes = 1 << size;
        return (adr % nbytes) != 0;
    endfunction

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (ack_o) begin
                exp_t e;
                n_acks++;
                if (sb.size() == 0) begin
                    check("unexpected_ack", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_q", q_o, e.q);
                    check("rsp_err", err_o, e.err);
                    check("rsp_mis", misaligned_o, e.mis);
                end
            end else begin
                check("flags_without_ack", {err_o, misaligned_o}, 0);
            end
        end
    end

    task automatic clear_biu();
        biu_stb_ack_i = 0; biu_d_ack_i = 0; biu_err_i = 0; flush_i = 0;
    endtask

    task automatic drive_resp(int resp, logic [31:0] rq);
        biu_q_i     = rq;
        biu_d_ack_i = (resp != 1);
        biu_err_i   = (resp != 0);
    endtask

    // Entered and left at posedge+1 with the DUT idle.
    // fph: 0 no flush, 1 flush in first STB cycle, 2 flush in first DATA cycle, 3 flush in RSP
    task automatic do_txn(logic [2:0] size, logic [33:0] adr, logic we, logic [31:0] d,
                          logic lock, logic [31:0] rq, int wstb, int wd, int resp, int fph);
        bit   mis;
        bit   killed;
        exp_t e;
        mis    = is_mis(size, adr);
        killed = 0;
        req_i = 1; adr_i = adr; size_i = size; we_i = we; d_i = d; lock_i = lock;
        @(posedge clk_i); #1;
        req_i = 0; adr_i = {2'b0, $urandom}; d_i = $urandom; we_i = ~we; lock_i = ~lock; size_i = ~size;
        if (!mis) begin
            for (int i = 0; i <= wstb; i++) begin
                biu_q_i = $urandom;
                if (fph == 1 && i == 0) begin flush_i = 1; killed = 1; end
                if (i == wstb) begin
                    biu_stb_ack_i = 1;
                    if (wd == 0) drive_resp(resp, rq);
                end
                @(negedge clk_i);
                check("stb_high", biu_stb_o, 1);
                check("stb_stall", stall_o, 1);
                check("stb_adr", biu_adri_o, adr);
                check("stb_d", biu_d_o, d);
                check("stb_we_lock", {biu_we_o, biu_lock_o, biu_size_o}, {we, lock, size});
                @(posedge clk_i); #1;
                clear_biu();
            end
            for (int i = 1; i <= wd; i++) begin
                biu_q_i = $urandom;
                if (fph == 2 && i == 1) begin flush_i = 1; killed = 1; end
                if (i == wd) drive_resp(resp, rq);
                @(negedge clk_i);
                check("data_stb_low", biu_stb_o, 0);
                check("data_stall", stall_o, 1);
                check("data_d", biu_d_o, d);
                @(posedge clk_i); #1;
                clear_biu();
            end
            if (!we) model_q = rq;
            e.err = (resp != 0);
            e.mis = 0;
        end else begin
            e.err = 0;
            e.mis = 1;
        end
        e.q = model_q;
        biu_stb_ack_i = 1'($urandom); biu_d_ack_i = 1'($urandom); biu_q_i = $urandom;
        if (fph == 3) begin flush_i = 1; killed = 1; end
        if (!killed) begin sb.push_back(e); n_pushed++; end
        @(negedge clk_i);
        check("ack_pulse", ack_o, !killed);
        check("rsp_stall", stall_o, 1);
        check("rsp_stb_low", biu_stb_o, 0);
        @(posedge clk_i); #1;
        clear_biu();
        @(negedge clk_i);
        check("idle_after_rsp", {stall_o, ack_o, biu_lock_o}, 0);
        @(posedge clk_i); #1;
    endtask

    task automatic idle_gap(int n);
        for (int i = 0; i < n; i++) begin
            biu_stb_ack_i = 1'($urandom); biu_d_ack_i = 1'($urandom);
            biu_err_i = 1'($urandom); biu_q_i = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                req_i = 1; flush_i = 1; adr_i = {2'b0, $urandom}; size_i = 3'($urandom_range(0, 3));
            end
            @(negedge clk_i);
            check("idle_stall", {stall_o, biu_stb_o}, 0);
            @(posedge clk_i); #1;
            req_i = 0;
            clear_biu();
        end
        @(negedge clk_i);
        check("idle_end_stall", stall_o, 0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  sz;
        logic [33:0] a;
        rst_ni = 0; req_i = 0; adr_i = 0; size_i = 0; lock_i = 0; we_i = 0; d_i = 0;
        biu_q_i = 0; model_q = 0;
        clear_biu();
        repeat (3) @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("reset_ctrl", {stall_o, ack_o, err_o, misaligned_o, biu_stb_o, biu_lock_o, biu_we_o}, 0);
        check("reset_q", q_o, 0);
        check("reset_d", biu_d_o, 0);
        check("reset_adr", biu_adri_o, 0);
        @(posedge clk_i); #1;
        rst_ni = 1;
        @(posedge clk_i); #1;

        // aligned word read, minimum latency
        do_txn(3'd2, 34'h100, 0, 32'h0, 0, 32'hDEADBEEF, 0, 0, 0, 0);
        check("q_hold_after_read", q_o, 32'hDEADBEEF);
        // wait-state write: 4 strobe cycles, 2 data waits
        do_txn(3'd2, 34'h200, 1, 32'h12345678, 1, 32'h0BADF00D, 3, 2, 0, 0);
        check("q_hold_after_write", q_o, 32'hDEADBEEF);
        // misaligned halfword
        do_txn(3'd1, 34'h101, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
        // bus error during DATA
        do_txn(3'd2, 34'h40, 0, 32'h0, 0, 32'hCAFE0001, 0, 2, 1, 0);
        // error and data ack together
        do_txn(3'd3, 34'h48, 0, 32'h0, 0, 32'hCAFE0002, 1, 0, 2, 0);
        // flush during DATA, then a normal request
        do_txn(3'd2, 34'h80, 0, 32'h0, 0, 32'h11112222, 0, 2, 0, 2);
        check("q_after_killed_read", q_o, 32'h11112222);
        do_txn(3'd0, 34'h83, 0, 32'h0, 0, 32'h33334444, 1, 1, 0, 0);
        // flush in STB and in RSP
        do_txn(3'd2, 34'h90, 1, 32'hA5A5A5A5, 0, 32'h0, 2, 1, 0, 1);
        do_txn(3'd1, 34'h93, 0, 32'h0, 0, 32'h0, 0, 0, 0, 3);
        idle_gap(4);

        // reset while in STB
        req_i = 1; adr_i = 34'h300; size_i = 3'd2; we_i = 1; d_i = 32'h5555AAAA; lock_i = 1;
        @(posedge clk_i); #1;
        req_i = 0;
        rst_ni = 0;
        @(negedge clk_i);
        check("rst_stb_before", biu_stb_o, 1);
        @(posedge clk_i); #1;
        rst_ni = 1;
        model_q = 0;
        @(negedge clk_i);
        check("rst_stb_after", {biu_stb_o, stall_o, biu_lock_o, ack_o}, 0);
        check("rst_q", q_o, 0);
        check("rst_bus", {biu_adri_o, biu_d_o, biu_we_o}, 0);
        @(posedge clk_i); #1;
        biu_stb_ack_i = 1; biu_d_ack_i = 1;
        idle_gap(3);

        for (int n = 0; n < 300; n++) begin
            int fph;
            sz = 3'($urandom_range(0, 3));
            a  = {2'($urandom), $urandom};
            if ($urandom_range(0, 3) != 0) a = a & ~(34'((1 << sz) - 1));
            fph = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_txn(sz, a, 1'($urandom), $urandom, 1'($urandom), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), fph);
            if ($urandom_range(0, 1) == 0) idle_gap($urandom_range(0, 2));
        end

        repeat (2) @(posedge clk_i);
        check("scoreboard_drained", sb.size(), 0);
        check("ack_count", n_acks, n_pushed);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_memrsp.md
RISCV_MEMRSP -- requirements
Module: riscv_memrsp

Interface
REQ-001 Parameter XLEN, default 32, data width of the CPU and BIU data paths.
REQ-002 Parameter PLEN, default 34 when XLEN==32 else 56, physical address width.
REQ-003 Clock and reset: one clock; reset is synchronous and active-low.
REQ-004 clk_i  in  1  clock; all state changes on its rising edge.
REQ-005 rst_ni  in  1  synchronous active-low reset.
REQ-006 Request side, translated request from the MMU stage:
- req_i  in  1  request valid
- adr_i  in  PLEN  physical address
- size_i  in  biu_size_t  access size
- lock_i  in  1  locked access
- we_i  in  1  write enable
- d_i  in  XLEN  write data
REQ-007 flush_i  in  1  abort or discard any outstanding response.
REQ-008 stall_o  out  1  high means the request is not accepted this cycle.
REQ-009 Response side to the CPU:
- ack_o  out  1  response valid
- q_o  out  XLEN  read data
- err_o  out  1  bus error response
- misaligned_o  out  1  misaligned-access response
REQ-010 BIU request outputs:
- biu_stb_o  out  1  request strobe
- biu_adri_o  out  PLEN  address
- biu_size_o  out  biu_size_t  size
- biu_lock_o  out  1  lock
- biu_we_o  out  1  write enable
- biu_d_o  out  XLEN  write data
REQ-011 BIU response inputs:
- biu_stb_ack_i  in  1  strobe accepted
- biu_d_ack_i  in  1  data phase done
- biu_q_i  in  XLEN  read data
- biu_err_i  in  1  bus error

Function
REQ-012 The block SHALL implement FSM states IDLE, STB, DATA and RSP, with one outstanding access at most.
REQ-013 stall_o SHALL equal (state != IDLE).
REQ-014 Acceptance rule: a request is accepted at a rising edge where state==IDLE, req_i==1 and flush_i==0.
REQ-015 On acceptance, adr_i, size_i, lock_i, we_i and d_i SHALL be registered into biu_*_o, and those outputs SHALL stay stable until the return to IDLE.
REQ-016 Misalignment is defined as follows: HWORD with adr[0]!=0, WORD with adr[1:0]!=0, DWORD with adr[2:0]!=0; BYTE is never misaligned.
REQ-017 An aligned accepted request SHALL go IDLE->STB; biu_stb_o SHALL be 1 exactly while state==STB.
REQ-018 A misaligned accepted request SHALL go IDLE->RSP with misaligned_o=1 and SHALL never assert biu_stb_o.
REQ-019 In STB, biu_stb_ack_i==1 SHALL move the FSM to DATA; if biu_d_ack_i or biu_err_i is also 1 in that cycle, the FSM SHALL go directly to RSP.
REQ-020 STB SHALL be held indefinitely until biu_stb_ack_i; the strobe SHALL never be withdrawn, including on flush_i.
REQ-021 In DATA, biu_d_ack_i or biu_err_i SHALL move the FSM to RSP, capture biu_q_i into q_o and set err_o=biu_err_i.
REQ-022 If biu_d_ack_i and biu_err_i are both 1, err_o SHALL be 1.
REQ-023 In RSP, ack_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; err_o and misaligned_o SHALL be valid only while ack_o==1 and 0 otherwise.
REQ-024 For writes, q_o SHALL be held at its previous value.
REQ-025 Minimum latency for an aligned access with biu_stb_ack_i and biu_d_ack_i high in the same cycle: accept at edge N, STB during N..N+1, ack_o high during cycle N+2.
REQ-026 flush_i in IDLE SHALL cause req_i to be ignored.
REQ-027 flush_i while in STB or DATA SHALL set a kill flag; the access SHALL complete on the BIU, but RSP SHALL drive ack_o=0, err_o=0 and misaligned_o=0.
REQ-028 The kill flag SHALL clear on the return to IDLE.
REQ-029 flush_i while in RSP SHALL suppress ack_o in that cycle.
REQ-030 biu_lock_o SHALL follow the registered lock_i and SHALL clear on the return to IDLE.
REQ-031 biu_stb_ack_i and biu_d_ack_i SHALL be ignored in IDLE and RSP.

Reset
REQ-032 When rst_ni==0 at a rising edge, the FSM SHALL go to IDLE and the kill flag SHALL clear.
REQ-033 The same reset SHALL drive stall_o=0, ack_o=0, err_o=0, misaligned_o=0, biu_stb_o=0, biu_lock_o=0, biu_we_o=0, q_o=0, biu_d_o=0 and biu_adri_o=0.
REQ-034 Reset mid-access SHALL drop biu_stb_o on the next edge; no response SHALL be issued for the interrupted access.

Verification
REQ-035 Aligned WORD read:
- stimulus: adr 0x100, size WORD; stb_ack and d_ack both high in the first STB cycle; biu_q_i 0xDEADBEEF
- required response: ack_o high 2 cycles after acceptance, q_o 0xDEADBEEF, err_o 0.
REQ-036 Wait-state write:
- stimulus: WORD write, d_i 0x12345678; stb_ack delayed 3 cycles, d_ack delayed 2 more cycles
- required response: biu_stb_o high for 4 cycles, biu_d_o 0x12345678 stable throughout, stall_o high until after the ack_o pulse, one ack_o pulse.
REQ-037 Misaligned HWORD:
- stimulus: HWORD at adr 0x101
- required response: biu_stb_o never 1; ack_o and misaligned_o both 1 one cycle after acceptance.
REQ-038 Bus error:
- stimulus: biu_err_i=1 during DATA on a read
- required response: ack_o=1 and err_o=1 for one cycle, then IDLE.
REQ-039 Flush during DATA:
- stimulus: pulse flush_i in DATA
- required response: BIU access completes; ack_o stays 0; the next request is accepted normally.
REQ-040 Reset during STB:
- stimulus: rst_ni=0 for one edge while in STB
- required response: biu_stb_o=0 and stall_o=0 after that edge; no ack_o pulse.
